// File: rtl/onecold_decoder_seq.sv
// One-cold select decoder with hold and break-before-make gap.
// Accepts an index over valid/ready. Drives the matching active-low select
// line for HOLD_CYCLES cycles. Then holds all lines high for GAP_CYCLES cycles
// before it accepts the next index.
// Optional: ONECOLD_DEC_ROUNDTRIP_CHECK_EN re-encodes sel_n during DRIVE and
// raises a sticky err on mismatch.
module onecold_decoder_seq #(
    parameter int IDX_W       = 2,
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 1,
    localparam int SEL_W      = 2 ** IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             in_ready,
    output logic [SEL_W-1:0] sel_n,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LD  = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             done_q, done_d;
    logic [SEL_W-1:0] dec_pat;

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign sel_n    = sel_q;
    assign done     = done_q;

    // Decode the index MSB-first: index 0 clears the top bit of sel_n.
    always_comb begin
        dec_pat = '1;
        for (int i = 0; i < SEL_W; i++) begin
            dec_pat[i] = (in_idx != IDX_W'(SEL_W - 1 - i));
        end
    end

    // Next-state logic. sel_n and done are registered, so they are computed here.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = '1;
                if (in_valid) begin
                    sel_d   = dec_pat;
                    cnt_d   = HOLD_LD;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == 8'd0) begin
                    sel_d = '1;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = GAP_LD;
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                sel_d = '1;
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '1;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State, counter and registered outputs. Reset drops any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            sel_q   <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

`ifdef ONECOLD_DEC_ROUNDTRIP_CHECK_EN
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_ok;
    logic             err_q, err_d;
    int               zeros;

    // Re-encode the driven pattern. The pattern is valid only when exactly one bit is low.
    always_comb begin
        zeros   = 0;
        enc_idx = '0;
        for (int i = 0; i < SEL_W; i++) begin
            if (!sel_q[i]) begin
                zeros   = zeros + 1;
                enc_idx = IDX_W'(SEL_W - 1 - i);
            end
        end
        enc_ok = (zeros == 1);
    end

    // Capture the accepted index. Latch err when a DRIVE cycle disagrees with it.
    always_comb begin
        idx_d = idx_q;
        if (state_q == IDLE && in_valid) idx_d = in_idx;
        err_d = err_q;
        if (state_q == DRIVE && (!enc_ok || enc_idx != idx_q)) err_d = 1'b1;
    end

    // Registered index copy and sticky error flag; only reset clears err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_onecold_decoder_seq.sv
// Directed bench for onecold_decoder_seq.
// DUT A runs with HOLD=1 and GAP=1. DUT B runs with HOLD=4 and GAP=0.
// The round-trip error injection step is built only when
// ONECOLD_DEC_ROUNDTRIP_CHECK_EN is defined.
module tb_onecold_decoder_seq;

    logic       clk;
    logic       rst;
    logic       a_valid, b_valid;
    logic [1:0] a_idx, b_idx;
    logic       a_ready, b_ready, a_busy, b_busy, a_done, b_done, a_err, b_err;
    logic [3:0] a_sel, b_sel;

    int total = 0;
    int bad   = 0;

    logic [3:0] pat [4];

    onecold_decoder_seq #(.IDX_W(2), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_idx(a_idx),
        .in_ready(a_ready), .sel_n(a_sel), .busy(a_busy), .done(a_done), .err(a_err)
    );

    onecold_decoder_seq #(.IDX_W(2), .HOLD_CYCLES(4), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_idx(b_idx),
        .in_ready(b_ready), .sel_n(b_sel), .busy(b_busy), .done(b_done), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pat[0] = 4'b0111; pat[1] = 4'b1011; pat[2] = 4'b1101; pat[3] = 4'b1110;
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_idx = 2'd0; b_idx = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        // Check the reset state of both instances.
        chk("rst_a_sel", a_sel, 4'b1111);  chk("rst_b_sel", b_sel, 4'b1111);
        chk("rst_a_ready", a_ready, 1);    chk("rst_a_busy", a_busy, 0);
        chk("rst_a_done", a_done, 0);      chk("rst_b_done", b_done, 0);
        chk("rst_a_err", a_err, 0);        chk("rst_b_err", b_err, 0);
        rst = 1'b0;
        step();

        // A: indices 0..3 back to back with in_valid held high; period is 3 cycles.
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_idx = 2'(i);
            chk("a_ready_idle", a_ready, 1);
            step();
            chk("a_sel_pat", a_sel, pat[i]);
            chk("a_busy_drive", a_busy, 1);
            chk("a_done_drive", a_done, 0);
            step();
            chk("a_sel_gap", a_sel, 4'b1111);
            chk("a_ready_gap", a_ready, 0);
            chk("a_done_gap", a_done, 0);
            step();
            chk("a_sel_idle", a_sel, 4'b1111);
            chk("a_done_pulse", a_done, 1);
            chk("a_ready_done", a_ready, 1);
        end
        a_valid = 1'b0;
        step();
        chk("a_done_clear", a_done, 0);

        // B: idx 2 holds 1101 for exactly 4 cycles, then done coincides with ready.
        b_valid = 1'b1; b_idx = 2'd2;
        step();
        b_valid = 1'b0;
        chk("b_hold0", b_sel, 4'b1101);
        for (int j = 1; j < 4; j++) begin
            step();
            chk("b_hold", b_sel, 4'b1101);
            chk("b_done_hold", b_done, 0);
        end
        step();
        chk("b_sel_end", b_sel, 4'b1111);
        chk("b_done_end", b_done, 1);
        chk("b_ready_end", b_ready, 1);
        step();
        chk("b_done_once", b_done, 0);

        // B: an index change while busy is ignored. Index 3 is taken on the edge that clears done.
        b_valid = 1'b1; b_idx = 2'd1;
        step();
        chk("b_chg_sel0", b_sel, 4'b1011);
        b_idx = 2'd3;
        for (int j = 1; j < 4; j++) begin
            step();
            chk("b_chg_sel", b_sel, 4'b1011);
            chk("b_chg_ready", b_ready, 0);
        end
        step();
        chk("b_chg_gapless", b_sel, 4'b1111);
        chk("b_chg_done", b_done, 1);
        chk("b_chg_ready1", b_ready, 1);
        step();
        chk("b_new_pat", b_sel, 4'b1110);
        chk("b_new_done", b_done, 0);
        b_valid = 1'b0;

        // Reset mid-DRIVE: B is driving idx 3 and A is driving idx 2.
        a_valid = 1'b1; a_idx = 2'd2;
        step();
        a_valid = 1'b0;
        chk("a_pre_rst", a_sel, 4'b1101);
        chk("b_pre_rst", b_sel, 4'b1110);
        #2 rst = 1'b1;
        #1;
        chk("b_arst_sel", b_sel, 4'b1111);  chk("b_arst_ready", b_ready, 1);
        chk("b_arst_busy", b_busy, 0);      chk("b_arst_done", b_done, 0);
        chk("a_arst_sel", a_sel, 4'b1111);  chk("a_arst_ready", a_ready, 1);
        chk("a_arst_busy", a_busy, 0);      chk("a_arst_done", a_done, 0);
        step();
        chk("b_rst_hold_done", b_done, 0);
        chk("a_rst_hold_done", a_done, 0);
        rst = 1'b0;
        b_valid = 1'b1; b_idx = 2'd0;
        step();
        chk("b_post_rst_pat", b_sel, 4'b0111);
        chk("b_post_rst_busy", b_busy, 1);
        b_valid = 1'b0;
        for (int n = 0; n < 20 && !b_done; n++) step();
        chk("b_post_rst_done", b_done, 1);
        step();

`ifdef ONECOLD_DEC_ROUNDTRIP_CHECK_EN
        // Corrupt sel_n during DRIVE. err must set on the next edge and stay set until reset.
        a_valid = 1'b1; a_idx = 2'd0;
        step();
        a_valid = 1'b0;
        chk("a_err_before", a_err, 0);
        force dut_a.sel_q = 4'b0011;
        step();
        release dut_a.sel_q;
        chk("a_err_set", a_err, 1);
        repeat (3) step();
        chk("a_err_sticky", a_err, 1);
        chk("b_err_clean", b_err, 0);
        rst = 1'b1;
        #1;
        chk("a_err_rst", a_err, 0);
        rst = 1'b0;
        step();
`else
        chk("a_err_off", a_err, 0);
        chk("b_err_off", b_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
